// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the accumulator and its adder.
package fp_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [7:0]      FP_EXP_INF  = 8'hFF;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RTZ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_DONE
  } acc_state_e;

  function automatic logic fp_is_nan(input logic [FP_W-1:0] v);
    return (v[30:23] == FP_EXP_INF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fadder.sv
// Combinational IEEE-754 single-precision add/subtract with four rounding modes.
module fadder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  input  logic            sub,
  input  logic [1:0]      rm,
  output logic [FP_W-1:0] y
);

  logic        sa, sb, sx, sy, a_big, eff_sub, inc, st, ovf_inf, zero_sign;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [9:0]  ex, ey, e, d;
  logic [26:0] mx, my, my_sh, m;
  logic [27:0] s;
  logic [24:0] mant;

  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ sub;
    a_nan = (a[30:23] == FP_EXP_INF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == FP_EXP_INF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == FP_EXP_INF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == FP_EXP_INF) && (b[22:0] == 23'd0);

    // Order operands by magnitude; mantissas carry hidden bit plus guard/round/sticky
    a_big = a[30:0] >= b[30:0];
    sx    = a_big ? sa : sb;
    sy    = a_big ? sb : sa;
    ex    = 10'(a_big ? a[30:23] : b[30:23]);
    ey    = 10'(a_big ? b[30:23] : a[30:23]);
    mx    = a_big ? {(a[30:23] != 8'd0), a[22:0], 3'b000} : {(b[30:23] != 8'd0), b[22:0], 3'b000};
    my    = a_big ? {(b[30:23] != 8'd0), b[22:0], 3'b000} : {(a[30:23] != 8'd0), a[22:0], 3'b000};
    if (ex == 10'd0) ex = 10'd1;
    if (ey == 10'd0) ey = 10'd1;

    d  = ex - ey;
    st = 1'b0;
    if (d >= 10'd27) begin
      my_sh = {26'd0, |my};
    end else begin
      st    = |(my & ((27'd1 << d) - 27'd1));
      my_sh = (my >> d) | {26'd0, st};
    end

    eff_sub = sx ^ sy;
    s = eff_sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});

    e = ex;
    if (s[27]) begin
      m = {s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      m = s[26:0];
    end
    // Left-normalise, stopping at the subnormal exponent
    for (int i = 0; i < 26; i++) begin
      if (!m[26] && (e > 10'd1)) begin
        m = m << 1;
        e = e - 10'd1;
      end
    end

    case (rm)
      RM_RNE:  inc = m[2] & (m[1] | m[0] | m[3]);
      RM_RDN:  inc = sx & (m[2] | m[1] | m[0]);
      RM_RUP:  inc = ~sx & (m[2] | m[1] | m[0]);
      default: inc = 1'b0;
    endcase

    mant = {1'b0, m[26:3]} + 25'(inc);
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 10'd1;
    end

    y = {sx, (mant[23] ? e[7:0] : 8'd0), mant[22:0]};

    case (rm)
      RM_RNE:  ovf_inf = 1'b1;
      RM_RDN:  ovf_inf = sx;
      RM_RUP:  ovf_inf = ~sx;
      default: ovf_inf = 1'b0;
    endcase
    if (mant[23] && (e >= 10'd255))
      y = ovf_inf ? {sx, FP_EXP_INF, 23'd0} : {sx, 8'hFE, 23'h7F_FFFF};

    // Exact zero: like-signed zeros keep their sign, otherwise -0 only when rounding down
    zero_sign = (sx == sy) ? sx : (rm == RM_RDN);
    if (s == 28'd0) y = {zero_sign, 31'd0};

    if (a_inf || b_inf) begin
      if (a_inf && b_inf && (sa != sb)) y = 32'h7FC0_0000;
      else                              y = a_inf ? {sa, FP_EXP_INF, 23'd0} : {sb, FP_EXP_INF, 23'd0};
    end
    if (a_nan || b_nan) y = 32'h7FC0_0000;
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming single-precision accumulator around the combinational fadder.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [1:0]       rm,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic             out_nan,
  output logic             out_ovf,
  output logic             busy
);

  acc_state_e       state_q;
  logic [CNT_W-1:0] rem_q;
  logic [FP_W-1:0]  acc_q, acc_d, x_q, sum_c;
  logic [1:0]       rm_q;
  logic             sub_q, pend_q, ovf_q, ovf_d, nan_q;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             clear_c, take_c;

  fadder u_fadder (
    .a   (acc_q),
    .b   (x_q),
    .sub (sub_q),
    .rm  (rm_q),
    .y   (sum_c)
  );

  // Accumulator next value: pending add result, or cleared by a new start
  always_comb begin
    clear_c = (state_q == ST_IDLE) && start;
    take_c  = in_valid && in_ready_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (pend_q) begin
      acc_d = sum_c;
      if ((acc_q[30:23] != FP_EXP_INF) && (x_q[30:23] != FP_EXP_INF) && (sum_c[30:23] == FP_EXP_INF))
        ovf_d = 1'b1;
    end
    if (clear_c) begin
      acc_d = FP_POS_ZERO;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      acc_q       <= FP_POS_ZERO;
      x_q         <= FP_POS_ZERO;
      rm_q        <= RM_RNE;
      sub_q       <= 1'b0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      nan_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      nan_q  <= fp_is_nan(acc_d);
      pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rm_q   <= rm;
            rem_q  <= len;
            busy_q <= 1'b1;
            if (len != '0) begin
              state_q    <= ST_ACC;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_ACC: begin
          if (take_c) begin
            x_q    <= in_data;
            sub_q  <= in_sub;
            pend_q <= 1'b1;
            rem_q  <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) in_ready_q <= 1'b0;
          end else if (rem_q == '0) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state_q     <= ST_DONE;
          out_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_nan   = nan_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential single-precision accumulator that wraps the team's combinational `fadder`. It accepts a length-tagged stream of IEEE-754 operands over a valid/ready handshake and feeds each operand, with the running sum, into `fadder`. It consumes the adder output back into the accumulator register and presents the final sum on an output handshake. It sits directly upstream and downstream of `fadder` and is the block the vector/dot-product datapath talks to.

## Interface
- `CNT_W`, 8: width of the element-count field; max stream length is 2^CNT_W−1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `start`  in  1  begin a new accumulation; sampled only in IDLE.
- `len`  in  CNT_W  number of elements; latched on start.
- `rm`  in  2  rounding mode (00 nearest-even, 01 down, 10 up, 11 toward zero); latched on start.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`.
- `in_data`  in  32  operand.
- `in_sub`  in  1  1: acc − in_data; 0: acc + in_data.
- `out_valid`  out  1  result valid; held until taken.
- `out_ready`  in  1  result taken when `out_valid & out_ready`.
- `out_sum`  out  32  accumulated result.
- `out_nan`  out  1  `out_sum` is NaN (exp 0xFF, frac ≠ 0).
- `out_ovf`  out  1  sticky: some add produced ±inf from two finite operands.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ACC, DRAIN, DONE.
- IDLE: `in_ready`=0. On `start`, latch `len` and `rm`, and set acc=0x00000000, ovf=0, pend=0.
  - `len`≠0 → ACC with remaining=`len`.
  - `len`=0 → DONE directly, with `out_sum`=0x00000000.
- ACC: `in_ready`=1.
  - On a handshake, capture `in_data` and `in_sub` into the operand register, set pend=1, and decrement remaining.
  - With no handshake, pend=0 and acc is unchanged; bubbles are legal.
  - When remaining reaches 0 (last element captured) → DRAIN.
- Add path:
  - Whenever pend=1, acc ← `fadder(a=acc, b=x_q, sub=sub_q, rm=rm_q)` at the next edge.
  - ovf is set if `acc` exp≠0xFF and `x_q` exp≠0xFF and the result exp=0xFF.
- DRAIN: one cycle; the final pending add completes. `in_ready`=0. Then → DONE.
- DONE: `out_valid`=1 and `out_sum`=acc, stable until `out_ready`. On the handshake → IDLE. `start` in that same cycle is ignored.
- `start` outside IDLE is ignored. `len` and `rm` changes after start have no effect.
- NaN propagates naturally through `fadder`. Accumulation continues for the remaining elements after a NaN.
- Reset at any time: state IDLE, all registers cleared, and any in-flight stream discarded.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_sum`=0x00000000, `out_nan`=0, `out_ovf`=0, `busy`=0.
- Throughput is one element per cycle. acc is updated exactly one cycle after the operand is captured, so back-to-back elements see the correct running sum.
- Latency: last element accepted at edge t → `out_valid` high after edge t+2.
- For `len`=0, `out_valid` is high one cycle after `start`.
- `fadder` stays purely combinational between the acc/operand registers and the acc D-input. There is no other logic in that path beyond the ovf compare.

## Structure
- Shared package `fp_pkg` holds:
  - the state enum;
  - `FP_POS_ZERO`=32'h00000000;
  - `FP_EXP_INF`=8'hFF;
  - `RM_RNE`/`RM_RDN`/`RM_RUP`/`RM_RTZ`.
- One sub-module: the existing `fadder`, instantiated once as `u_fadder`. No other hierarchy.

## Test plan
- start, len=3, rm=00; stream 0x3F800000, 0x40000000, 0x40400000 (all add) back-to-back.
  - Expect `out_sum`=0x40C00000 two cycles after the last accept, with `out_nan`=0 and `out_ovf`=0.
- len=2; 0x3F800000 add, then 0x3F800000 sub, with one idle cycle between.
  - Expect `out_sum`=0x00000000, arriving two cycles after the second accept.
- len=2; 0x7F7FFFFF, 0x7F7FFFFF:
  - rm=00 → 0x7F800000 with `out_ovf`=1.
  - rm=11 → 0x7F7FFFFF with `out_ovf`=0.
- len=3; 0x3F800000, 0x7FC00000, 0x40000000.
  - Expect `out_nan`=1 and `out_sum` exp=0xFF.
- len=0 → `out_valid` after one cycle with 0x00000000.
  - Hold `out_ready`=0 for 5 cycles: `out_sum` stays stable and `in_ready` stays 0.
  - `start` pulsed during DONE is ignored.
- `rst` asserted after 2 of 4 elements.
  - Next cycle: all outputs at reset values.
  - A new len=1 run with 0x40400000 then returns 0x40400000.
